qrs_mp_avg_pipe: RTL and testbench
==================================

# qrs_mp_avg_pipe

Pipelined, parametrised multiscale-product averager for the QRS detector. It runs after the wavelet decomposition stage. Each sample, it forms the product of one pair of wavelet detail coefficients, chosen by the noise condition: D1·D2 for low noise, D3·D4 for high noise. It applies the noise-dependent weight, 9/8 or 3/8, and keeps a moving average over a 2^LOG2_WIN-sample window. The result feeds the adaptive threshold stage.

## Interface
- DW, 16, detail-coefficient width (signed two's complement)
- LOG2_WIN, 3, log2 of moving-average window length WIN (1..8)
- PW, 2*DW+1, derived width of the weighted product; not overridden
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous flush of window and pipeline
- in_valid  in  1  d1..d4/sel_hi_noise valid this cycle
- d1, d2, d3, d4  in  DW  signed detail coefficients, scales 1..4
- sel_hi_noise  in  1  1 = high noise (D3·D4, ×3/8); 0 = low noise (D1·D2, ×9/8)
- out_valid  out  1  mp/mp_avg valid this cycle
- mp  out  PW  signed weighted product of the sample
- mp_avg  out  PW  signed moving average of mp over the last WIN accepted samples
- avg_full  out  1  window holds WIN real samples since reset/clr

## Operation
- Streaming, with no backpressure.
  - in_valid may follow any pattern.
  - Bubbles do not advance the window.
- Stage 1: p = sel_hi_noise ? d3*d4 : d1*d2.
  - The product is a 2DW-bit signed value.
  - sel_hi_noise is sampled with the same in_valid as the data.
- Stage 2: w = sel ? (3*p)>>>3 : (9*p)>>>3.
  - The intermediate is computed at 2DW+4 bits.
  - The shift is arithmetic, so results floor toward −∞.
  - The result is truncated to PW bits. It always fits, including with all inputs at −2^(DW−1).
- Stage 3: window update.
  - Circular buffer of WIN×PW entries, with write pointer wp.
  - sum' = sum + w − buf[wp]; buf[wp] = w; wp increments and wraps WIN−1 → 0.
  - sum is PW+LOG2_WIN bits and cannot overflow.
  - mp_avg = sum' >>> LOG2_WIN, floor.
- Warm-up behaviour:
  - Buffer entries are 0 after reset/clr.
  - The average divides by WIN before the window is full. There is no partial-count division.
  - fill counter: saturates at WIN; avg_full = (fill == WIN).
- Mode change mid-window: no flush. Each buffered entry keeps the weight it was computed with.
- clr:
  - Cancels all in-flight pipeline valids.
  - Zeros sum, wp and fill. avg_full drops on the next cycle.
  - Buffer contents are not cleared; entries are only overwritten by later samples, and sum is zeroed.
  - Any in_valid in the clr cycle is dropped.
- rst, mid-operation or otherwise: same effect as clr, plus all outputs go to 0 immediately (asynchronously).

## Timing
- Reset values: out_valid=0, mp=0, mp_avg=0, avg_full=0. Internal sum, wp, fill and stage valids are 0.
- Latency is 3 cycles. A sample accepted at edge k has out_valid, mp and mp_avg registered at edge k+3.
- Throughput: 1 sample/cycle.
- mp and mp_avg hold their last values while out_valid=0.
- avg_full rises in the same cycle as the out_valid of the WIN-th sample.
- A clr at edge k suppresses out_valid for samples accepted at edges k−2..k.

## Test plan
All scenarios use DW=16, LOG2_WIN=3.
- Reset: assert rst asynchronously mid-cycle with a pipeline full of valid samples.
  - All outputs are 0 immediately.
  - No out_valid appears for 3 cycles after release.
- Low noise: sel=0, d1=100, d2=200, single pulse at edge 0.
  - Edge 3: out_valid=1, mp=22500, mp_avg=2812, avg_full=0.
- High noise, negative: sel=1, d3=−40, d4=50 from reset.
  - mp=−750, mp_avg=−94 (floor).
- Fill and slide: 8 samples of (sel=0, 100, 200), with random in_valid bubbles between them.
  - 8th output: mp_avg=22500, avg_full=1.
  - 9th sample with d1=0: mp_avg=19687.
- Extremes: sel=0, d1=d2=−32768.
  - mp=1207959552.
  - 8 such samples: mp_avg=1207959552, with no wrap.
  - Repeat with sel=1: mp=402653184.
- clr mid-stream: clr one cycle after 2 samples were accepted.
  - Neither sample emits out_valid.
  - Next sample (sel=0, 8, 8): mp=72, mp_avg=9, avg_full=0.

Source files
------------

// File: rtl/qrs_mp_avg_pipe_if.sv
// Streaming bus between the wavelet stage, the multiscale-product averager
// and the adaptive threshold stage. clr travels with the data stream.
interface qrs_mp_avg_pipe_if #(
  parameter int DW = 16
);
  localparam int PW = 2 * DW + 1;

  logic                 clr;
  logic                 in_valid;
  logic signed [DW-1:0] d1;
  logic signed [DW-1:0] d2;
  logic signed [DW-1:0] d3;
  logic signed [DW-1:0] d4;
  logic                 sel_hi_noise;
  logic                 out_valid;
  logic signed [PW-1:0] mp;
  logic signed [PW-1:0] mp_avg;
  logic                 avg_full;

  modport master (
    output clr, in_valid, d1, d2, d3, d4, sel_hi_noise,
    input  out_valid, mp, mp_avg, avg_full
  );

  modport slave (
    input  clr, in_valid, d1, d2, d3, d4, sel_hi_noise,
    output out_valid, mp, mp_avg, avg_full
  );
endinterface

// File: rtl/qrs_mp_avg_pipe.sv
// Multiscale-product averager: selects D1*D2 or D3*D4 by noise condition,
// applies 9/8 or 3/8 weight, and keeps a 2^LOG2_WIN-sample moving average.
// Pipeline: product -> weight -> window update -> output register.
module qrs_mp_avg_pipe #(
  parameter int DW       = 16,
  parameter int LOG2_WIN = 3
) (
  input logic clk,
  input logic rst,
  qrs_mp_avg_pipe_if.slave bus
);
  localparam int PW  = 2 * DW + 1;
  localparam int XW  = 2 * DW + 4;
  localparam int SW  = PW + LOG2_WIN;
  localparam int WIN = 1 << LOG2_WIN;
  localparam logic [LOG2_WIN:0] FILL_MAX = (LOG2_WIN + 1)'(WIN);

  logic                   v1, v2, v3;
  logic                   s1;
  logic signed [2*DW-1:0] p1;
  logic signed [PW-1:0]   w2, w3;
  logic signed [2*DW-1:0] p_c;
  logic signed [XW-1:0]   p_x, k_x;
  logic signed [PW-1:0]   w_c;
  logic signed [PW-1:0]   old_c;
  logic signed [SW-1:0]   sum, sum_next;
  logic [LOG2_WIN-1:0]    wp;
  logic [LOG2_WIN:0]      fill;
  logic signed [PW-1:0]   win_mem [WIN];

  // Stage 1 product: pick the coefficient pair for the current noise mode.
  always_comb begin
    p_c = bus.sel_hi_noise ? (2*DW)'(bus.d3) * (2*DW)'(bus.d4)
                           : (2*DW)'(bus.d1) * (2*DW)'(bus.d2);
  end

  // Stage 1 register; samples arriving with clr are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      s1 <= 1'b0;
      p1 <= '0;
    end else begin
      v1 <= bus.in_valid & ~bus.clr;
      if (bus.in_valid) begin
        p1 <= p_c;
        s1 <= bus.sel_hi_noise;
      end
    end
  end

  // Stage 2 weight: 3p or 9p by shift-add, then floor-divide by 8.
  always_comb begin
    p_x = XW'(p1);
    k_x = s1 ? (p_x <<< 1) + p_x : (p_x <<< 3) + p_x;
    w_c = PW'(k_x >>> 3);
  end

  // Stage 2 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0;
      w2 <= '0;
    end else begin
      v2 <= v1 & ~bus.clr;
      if (v1) w2 <= w_c;
    end
  end

  // Slots not yet written since reset/clr count as zero, so stale entries
  // left behind by clr never leak into the running sum.
  always_comb begin
    old_c    = (fill == FILL_MAX) ? win_mem[wp] : '0;
    sum_next = sum + SW'(w2) - SW'(old_c);
  end

  // Stage 3 window bookkeeping: running sum, write pointer, fill count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3   <= 1'b0;
      w3   <= '0;
      sum  <= '0;
      wp   <= '0;
      fill <= '0;
    end else if (bus.clr) begin
      v3   <= 1'b0;
      sum  <= '0;
      wp   <= '0;
      fill <= '0;
    end else begin
      v3 <= v2;
      if (v2) begin
        w3  <= w2;
        sum <= sum_next;
        wp  <= wp + 1'b1;
        if (fill != FILL_MAX) fill <= fill + 1'b1;
      end
    end
  end

  // Stage 3 window storage; deliberately not cleared.
  always_ff @(posedge clk) begin
    if (v2 && !bus.clr) win_mem[wp] <= w2;
  end

  // Output register; mp/mp_avg hold between valid samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.mp        <= '0;
      bus.mp_avg    <= '0;
      bus.avg_full  <= 1'b0;
    end else begin
      bus.out_valid <= v3;
      bus.avg_full  <= (fill == FILL_MAX);
      if (v3) begin
        bus.mp     <= w3;
        bus.mp_avg <= PW'(sum >>> LOG2_WIN);
      end
    end
  end
endmodule

// File: tb/tb_qrs_mp_avg_pipe.sv
// Bench for qrs_mp_avg_pipe: arithmetic reference model with per-cycle
// compare, plus directed scenarios with literal expectations.
module tb_qrs_mp_avg_pipe;
  localparam int DW = 16;
  localparam int LW = 3;
  localparam int WN = 8;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 0;

  qrs_mp_avg_pipe_if #(.DW(DW)) bus ();

  qrs_mp_avg_pipe #(.DW(DW), .LOG2_WIN(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, got timeout required finish");
    $fatal(1);
  end

  function automatic longint fdiv(longint a, longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  // Reference model: each accepted sample becomes due three edges later;
  // the window is a plain list of the last WN weighted products.
  typedef struct { int due; longint w; } pend_t;
  pend_t  pend [$];
  longint win_q [$];
  int     cyc = 0;
  bit     exp_valid = 0;
  bit     exp_full = 0;
  longint exp_mp = 0;
  longint exp_avg = 0;

  initial begin
    pend_t  e;
    longint p, s;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        pend.delete();
        win_q.delete();
        exp_valid = 0;
        exp_full  = 0;
        exp_mp    = 0;
        exp_avg   = 0;
        cyc       = 0;
      end else begin
        cyc++;
        exp_valid = 0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
          e = pend.pop_front();
          win_q.push_back(e.w);
          if (win_q.size() > WN) void'(win_q.pop_front());
          s = 0;
          foreach (win_q[i]) s += win_q[i];
          exp_valid = 1;
          exp_mp    = e.w;
          exp_avg   = fdiv(s, WN);
        end
        exp_full = (win_q.size() == WN);
        if (bus.clr) begin
          pend.delete();
          win_q.delete();
        end else if (bus.in_valid) begin
          if (bus.sel_hi_noise) begin
            p = longint'(bus.d3) * longint'(bus.d4);
            e.w = fdiv(p * 3, 8);
          end else begin
            p = longint'(bus.d1) * longint'(bus.d2);
            e.w = fdiv(p * 9, 8);
          end
          e.due = cyc + 3;
          pend.push_back(e);
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        chk("cyc_out_valid", longint'(bus.out_valid), longint'(exp_valid));
        chk("cyc_mp",        longint'(bus.mp),        exp_mp);
        chk("cyc_mp_avg",    longint'(bus.mp_avg),    exp_avg);
        chk("cyc_avg_full",  longint'(bus.avg_full),  longint'(exp_full));
      end
    end
  end

  task automatic send(bit s, int a, int b, int c, int d);
    bus.in_valid     = 1;
    bus.sel_hi_noise = s;
    bus.d1 = 16'(a);
    bus.d2 = 16'(b);
    bus.d3 = 16'(c);
    bus.d4 = 16'(d);
    @(negedge clk);
    bus.in_valid = 0;
  endtask

  task automatic wait_out(string nm, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no out_valid required out_valid within 12 cycles", nm);
    end
  endtask

  task automatic do_reset();
    #2 rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1;
    bus.clr = 0;
    bus.in_valid = 0;
    bus.sel_hi_noise = 0;
    bus.d1 = 0; bus.d2 = 0; bus.d3 = 0; bus.d4 = 0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_mp",        longint'(bus.mp),        0);
    chk("rst_mp_avg",    longint'(bus.mp_avg),    0);
    chk("rst_avg_full",  longint'(bus.avg_full),  0);
    rst = 0;
    chk_en = 1;

    // Low noise single pulse.
    send(0, 100, 200, 0, 0);
    wait_out("lo", lat);
    chk("lo_latency", lat, 3);
    chk("lo_mp", longint'(bus.mp), 22500);
    chk("lo_mp_avg", longint'(bus.mp_avg), 2812);
    chk("lo_avg_full", longint'(bus.avg_full), 0);
    chk("lo_model_mp", exp_mp, 22500);
    chk("lo_model_avg", exp_avg, 2812);

    // High noise, negative product, floor rounding.
    do_reset();
    send(1, 0, 0, -40, 50);
    wait_out("hi", lat);
    chk("hi_mp", longint'(bus.mp), -750);
    chk("hi_mp_avg", longint'(bus.mp_avg), -94);
    chk("hi_model_avg", exp_avg, -94);

    // Fill and slide with random bubbles.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      send(0, 100, 200, 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    chk("fill7_avg_full", longint'(bus.avg_full), 0);
    chk("fill7_mp_avg", longint'(bus.mp_avg), 19687);
    send(0, 100, 200, 0, 0);
    wait_out("fill8", lat);
    chk("fill8_mp_avg", longint'(bus.mp_avg), 22500);
    chk("fill8_avg_full", longint'(bus.avg_full), 1);
    chk("fill8_model_avg", exp_avg, 22500);
    send(0, 0, 200, 0, 0);
    wait_out("slide9", lat);
    chk("slide9_mp", longint'(bus.mp), 0);
    chk("slide9_mp_avg", longint'(bus.mp_avg), 19687);
    chk("slide9_avg_full", longint'(bus.avg_full), 1);

    // Asynchronous reset with a busy pipeline.
    for (int i = 0; i < 4; i++) send(1, 0, 0, -40, 50);
    chk("prerst_out_valid", longint'(bus.out_valid), 1);
    chk("prerst_mp", longint'(bus.mp), -750);
    #2 rst = 1;
    #1;
    chk("arst_out_valid", longint'(bus.out_valid), 0);
    chk("arst_mp",        longint'(bus.mp),        0);
    chk("arst_mp_avg",    longint'(bus.mp_avg),    0);
    chk("arst_avg_full",  longint'(bus.avg_full),  0);
    @(negedge clk);
    rst = 0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("postrst_quiet", seen, 0);

    // Extremes: no wrap in product, weight or sum.
    for (int i = 0; i < 8; i++) send(0, -32768, -32768, 0, 0);
    repeat (3) @(negedge clk);
    chk("ext_out_valid", longint'(bus.out_valid), 1);
    chk("ext_mp", longint'(bus.mp), 1207959552);
    chk("ext_mp_avg", longint'(bus.mp_avg), 1207959552);
    chk("ext_avg_full", longint'(bus.avg_full), 1);
    send(1, 0, 0, -32768, -32768);
    wait_out("ext_hi", lat);
    chk("ext_hi_mp", longint'(bus.mp), 402653184);
    chk("ext_hi_mp_avg", longint'(bus.mp_avg), 1107296256);

    // clr one cycle after two accepted samples.
    send(0, 100, 200, 0, 0);
    send(0, 100, 200, 0, 0);
    bus.clr = 1;
    @(negedge clk);
    bus.clr = 0;
    send(0, 8, 8, 0, 0);
    chk("clr_full_drop", longint'(bus.avg_full), 0);
    wait_out("clr", lat);
    chk("clr_latency", lat, 3);
    chk("clr_mp", longint'(bus.mp), 72);
    chk("clr_mp_avg", longint'(bus.mp_avg), 9);
    chk("clr_avg_full", longint'(bus.avg_full), 0);
    chk("clr_model_avg", exp_avg, 9);

    repeat (4) @(negedge clk);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
